// File: rtl/bcast_fanout_pkg.sv
// Shared helpers for the broadcast fan-out buffer: width functions and the
// head-retire (done) reduction.
package bcast_fanout_pkg;

  // Widest channel vector the done reduction accepts.
  localparam int MAX_NOUT = 64;

  // Widths for the default configuration (DEPTH=2).
  localparam int DEFAULT_DEPTH = 2;
  localparam int DEFAULT_PTR_W = (DEFAULT_DEPTH > 1) ? $clog2(DEFAULT_DEPTH) : 1;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_DEPTH + 1);

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // The head retires once every channel has taken it, is masked off,
  // or is accepting it right now. Bits at index n and above are ignored.
  function automatic logic head_done(input logic [MAX_NOUT-1:0] taken,
                                     input logic [MAX_NOUT-1:0] en,
                                     input logic [MAX_NOUT-1:0] acc,
                                     input int                  n);
    logic d;
    d = 1'b1;
    for (int i = 0; i < MAX_NOUT; i++) begin
      if (i < n) d = d & (taken[i] | ~en[i] | acc[i]);
    end
    return d;
  endfunction

endpackage

// File: rtl/bcast_fanout_store.sv
// DEPTH x WIDTH register array: synchronous write, combinational read,
// cleared by the asynchronous reset.
module bcast_fanout_store
  import bcast_fanout_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (we && (wr_ptr == PTR_W'(gi))) begin
        mem_reg[gi] <= wr_data;
      end
    end
  end

  assign rd_data = mem_reg[rd_ptr];

endmodule

// File: rtl/bcast_fanout_buf.sv
// One producer broadcast to NOUT consumers through a DEPTH-entry FIFO; the
// head retires once every enabled channel has accepted it exactly once.
module bcast_fanout_buf
  import bcast_fanout_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NOUT  = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [NOUT-1:0]            chan_en,
  output logic [NOUT-1:0]            out_valid,
  input  logic [NOUT-1:0]            out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [NOUT-1:0]  taken_reg, taken_next;

  logic            not_empty;
  logic            push;
  logic            pop;
  logic            done;
  logic [NOUT-1:0] acc;

  assign not_empty = (count_reg != '0);
  // Full is judged on registered state only, so no out_ready -> in_ready path.
  assign in_ready  = (count_reg < FULL_CNT);
  assign push      = in_valid & in_ready;

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_chan
    assign out_valid[gi] = not_empty & chan_en[gi] & ~taken_reg[gi];
    assign acc[gi]       = out_valid[gi] & out_ready[gi];
  end

  assign done  = head_done(MAX_NOUT'(taken_reg), MAX_NOUT'(chan_en),
                           MAX_NOUT'(acc), NOUT);
  assign pop   = not_empty & done;
  assign level = count_reg;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    taken_next  = taken_reg | acc;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      taken_next  = '0;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      taken_reg  <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      taken_reg  <= taken_next;
    end
  end

  bcast_fanout_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (push),
    .wr_ptr  (wr_ptr_reg),
    .wr_data (in_data),
    .rd_ptr  (rd_ptr_reg),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_bcast_fanout_buf.sv
// Directed bench for bcast_fanout_buf (WIDTH=8, NOUT=4, DEPTH=2); inputs and
// checks happen just after the falling edge.
module tb_bcast_fanout_buf;

  localparam int WIDTH = 8;
  localparam int NOUT  = 4;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [NOUT-1:0]  chan_en;
  logic [NOUT-1:0]  out_valid;
  logic [NOUT-1:0]  out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;

  int n_checks = 0;
  int n_errors = 0;

  bcast_fanout_buf #(
    .WIDTH (WIDTH),
    .NOUT  (NOUT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .chan_en   (chan_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to the next falling edge, apply inputs, let combinational logic settle.
  task automatic drive(input logic iv, input logic [WIDTH-1:0] d,
                       input logic [NOUT-1:0] en, input logic [NOUT-1:0] rdy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    chan_en   = en;
    out_ready = rdy;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [NOUT-1:0] v,
                            input logic [LW-1:0] lv);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".level"}, 32'(level), 32'(lv));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    chan_en   = 4'b1111;
    out_ready = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    expect_out("reset", 4'b0000, 2'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single broadcast: accepted everywhere on first presentation.
    drive(1'b1, 8'hA5, 4'b1111, 4'b1111);
    check("bcast.in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 8'h00, 4'b1111, 4'b1111);
    expect_out("bcast.head", 4'b1111, 2'd1);
    check("bcast.data", 32'(out_data), 32'hA5);
    drive(1'b0, 8'h00, 4'b1111, 4'b1111);
    expect_out("bcast.after", 4'b0000, 2'd0);

    // Staggered acceptance.
    drive(1'b1, 8'hA5, 4'b1111, 4'b0000);
    drive(1'b1, 8'h3C, 4'b1111, 4'b0000);
    drive(1'b0, 8'h00, 4'b1111, 4'b0001);
    expect_out("stag.c0", 4'b1111, 2'd2);
    check("stag.c0.data", 32'(out_data), 32'hA5);
    drive(1'b0, 8'h00, 4'b1111, 4'b0010);
    check("stag.c1.out_valid", 32'(out_valid), 32'b1110);
    drive(1'b0, 8'h00, 4'b1111, 4'b0100);
    check("stag.c2.out_valid", 32'(out_valid), 32'b1100);
    drive(1'b0, 8'h00, 4'b1111, 4'b1000);
    check("stag.c3.out_valid", 32'(out_valid), 32'b1000);
    check("stag.c3.data", 32'(out_data), 32'hA5);
    drive(1'b0, 8'h00, 4'b1111, 4'b0000);
    expect_out("stag.next", 4'b1111, 2'd1);
    check("stag.next.data", 32'(out_data), 32'h3C);
    drive(1'b0, 8'h00, 4'b1111, 4'b1111);
    drive(1'b0, 8'h00, 4'b1111, 4'b0000);
    check("stag.empty.level", 32'(level), 32'd0);

    // Full and backpressure; no pop-to-push bypass.
    drive(1'b1, 8'h11, 4'b1111, 4'b0000);
    drive(1'b1, 8'h22, 4'b1111, 4'b0000);
    drive(1'b1, 8'h33, 4'b1111, 4'b0000);
    check("full.level", 32'(level), 32'd2);
    check("full.in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 8'h33, 4'b1111, 4'b1111);
    check("full.pop.in_ready", 32'(in_ready), 32'd0);
    check("full.pop.data", 32'(out_data), 32'h11);
    drive(1'b1, 8'h33, 4'b1111, 4'b1111);
    check("full.after.in_ready", 32'(in_ready), 32'd1);
    check("full.after.data", 32'(out_data), 32'h22);
    check("full.after.level", 32'(level), 32'd1);
    drive(1'b0, 8'h00, 4'b1111, 4'b1111);
    check("full.third.data", 32'(out_data), 32'h33);
    check("full.third.level", 32'(level), 32'd1);
    drive(1'b0, 8'h00, 4'b1111, 4'b0000);
    expect_out("full.empty", 4'b0000, 2'd0);

    // Mask change mid-entry.
    drive(1'b1, 8'h5A, 4'b1111, 4'b0000);
    drive(1'b0, 8'h00, 4'b1111, 4'b0000);
    check("mask.head.out_valid", 32'(out_valid), 32'b1111);
    drive(1'b0, 8'h00, 4'b0101, 4'b0001);
    check("mask.narrow.out_valid", 32'(out_valid), 32'b0101);
    drive(1'b0, 8'h00, 4'b0101, 4'b0100);
    expect_out("mask.c2", 4'b0100, 2'd1);
    check("mask.c2.data", 32'(out_data), 32'h5A);
    drive(1'b0, 8'h00, 4'b0101, 4'b0000);
    expect_out("mask.done", 4'b0000, 2'd0);

    // Drain with every channel masked off.
    drive(1'b1, 8'h77, 4'b1111, 4'b0000);
    drive(1'b1, 8'h88, 4'b1111, 4'b0000);
    drive(1'b0, 8'h00, 4'b0000, 4'b0000);
    expect_out("drain.0", 4'b0000, 2'd2);
    check("drain.0.in_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 8'h00, 4'b0000, 4'b1111);
    expect_out("drain.1", 4'b0000, 2'd1);
    check("drain.1.in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 8'h00, 4'b0000, 4'b0000);
    expect_out("drain.2", 4'b0000, 2'd0);

    // Reset mid-stream takes effect without a clock edge.
    drive(1'b1, 8'hC1, 4'b1111, 4'b0000);
    drive(1'b1, 8'hC2, 4'b1111, 4'b0000);
    drive(1'b0, 8'h00, 4'b1111, 4'b0000);
    check("rst.pre.level", 32'(level), 32'd2);
    rst_n = 1'b0;
    #1;
    expect_out("rst.async", 4'b0000, 2'd0);
    check("rst.async.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'hD4, 4'b1111, 4'b0000);
    drive(1'b0, 8'h00, 4'b1111, 4'b0000);
    expect_out("rst.fresh", 4'b1111, 2'd1);
    check("rst.fresh.data", 32'(out_data), 32'hD4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
